// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer port arbiter.
//   DEF_FB_X_BITS / DEF_FB_Y_BITS : default framebuffer geometry
//   FB_ADDR_BITS                  : RAM address width ({row, col})
//   READ_LATENCY                  : rd_valid -> rd_color latency in cycles
//   clr_state_t                   : clear sequencer states
//   gnt_t                         : owner of the RAM port in a given cycle
package fb_pkg;
  localparam int DEF_FB_X_BITS = 9;
  localparam int DEF_FB_Y_BITS = 9;
  localparam int FB_ADDR_BITS  = DEF_FB_X_BITS + DEF_FB_Y_BITS;
  localparam int READ_LATENCY  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_CLEAR,
    GNT_WRITE
  } gnt_t;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_ram_if: bus to a single-port synchronous framebuffer RAM.
//   en, we, addr, wdata : command, driven by the master (arbiter)
//   rdata               : read data, valid one cycle after a read command
// Modports: master (arbiter side), slave (RAM side).
interface fb_ram_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_BITS,
  parameter int DATA_W = 1
) ();
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO holding pending {addr, data} framebuffer writes.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : enqueue din; ignored when full, even with a simultaneous pop
//   pop      : dequeue; ignored when empty
//   full     : DEPTH entries held
//   empty    : no entries held
//   dout     : oldest entry (show-ahead)
module fb_wr_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full    = count[PTR_W];
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM between the VGA
// pixel fetch (absolute priority, fixed latency READ_LATENCY), a FIFO of
// serial-link pixel writes, and a whole-framebuffer clear sequencer.
//   clk, rst                 : clock, synchronous active-high reset
//   rd_valid, rd_x, rd_y     : VGA pixel request (screen coordinates)
//   rd_color, rd_color_valid : fetched pixel, 3 cycles after the request
//   wr_valid/wr_ready        : write handshake; wr_addr {row, col}, wr_data
//   clr_req, clr_color       : start a clear with the given fill colour
//   clr_busy, clr_done       : clear in progress / one-cycle completion pulse
//   ram                      : fb_ram_if master port to the RAM (registered)
// Optional: FB_PORT_ARBITER_STATS_EN adds wr_stall_count, a saturating count
// of cycles with wr_valid && !wr_ready.
//
// state    | meaning
// ST_IDLE  | no clear running; free slots retire FIFO writes
// ST_CLEAR | free slots write clr_color to clr_addr, FIFO waits
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int PIXEL_DIM_WIDTH = 12,
  parameter int COLOR_BITS      = 1,
  parameter int SCALE_SHIFT     = 2,
  parameter int FB_X_BITS       = DEF_FB_X_BITS,
  parameter int FB_Y_BITS       = DEF_FB_Y_BITS,
  parameter int WR_FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_valid,
  input  logic [PIXEL_DIM_WIDTH-1:0]     rd_x,
  input  logic [PIXEL_DIM_WIDTH-1:0]     rd_y,
  output logic [COLOR_BITS-1:0]          rd_color,
  output logic                           rd_color_valid,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [FB_X_BITS+FB_Y_BITS-1:0] wr_addr,
  input  logic [COLOR_BITS-1:0]          wr_data,
  input  logic                           clr_req,
  input  logic [COLOR_BITS-1:0]          clr_color,
  output logic                           clr_busy,
  output logic                           clr_done,
  fb_ram_if.master                       ram
`ifdef FB_PORT_ARBITER_STATS_EN
  ,output logic [15:0]                   wr_stall_count
`endif
);
  localparam int AB = FB_X_BITS + FB_Y_BITS;
  localparam int CB = COLOR_BITS;

  logic [PIXEL_DIM_WIDTH-1:0] fx, fy;
  logic                       rd_hit;
  logic [AB-1:0]              rd_addr;
  gnt_t                       gnt;

  clr_state_t    state_q, state_d;
  logic [AB-1:0] clr_addr_q, clr_addr_d;
  logic [CB-1:0] clr_color_q, clr_color_d;
  logic          clr_done_q, clr_done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AB+CB-1:0]  fifo_dout;

  logic              ram_en_q, ram_we_q;
  logic [AB-1:0]     ram_addr_q;
  logic [CB-1:0]     ram_wdata_q;
  logic [READ_LATENCY-2:0] rd_vld_sr;

  // Screen -> framebuffer mapping; anything beyond the framebuffer is out of range.
  assign fx      = rd_x >> SCALE_SHIFT;
  assign fy      = rd_y >> SCALE_SHIFT;
  assign rd_hit  = rd_valid && ((fx >> FB_X_BITS) == '0) && ((fy >> FB_Y_BITS) == '0);
  assign rd_addr = {fy[FB_Y_BITS-1:0], fx[FB_X_BITS-1:0]};

  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_done  = clr_done_q;
  assign wr_ready  = !rst && !fifo_full && !clr_busy;
  assign fifo_push = wr_valid && wr_ready;
  assign fifo_pop  = (gnt == GNT_WRITE);

  fb_wr_fifo #(
    .WIDTH (AB + CB),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({wr_addr, wr_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (rd_hit)                  gnt = GNT_READ;
    else if (state_q == ST_CLEAR) gnt = GNT_CLEAR;
    else if (!fifo_empty)        gnt = GNT_WRITE;
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clr_color;
        end
      end
      ST_CLEAR: begin
        // Address only advances on a slot actually granted, so reads never lose a clear write.
        if (gnt == GNT_CLEAR) begin
          if (&clr_addr_q) begin
            state_d    = ST_IDLE;
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + AB'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      clr_done_q  <= clr_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_en_q <= (gnt != GNT_NONE);
      ram_we_q <= (gnt == GNT_CLEAR) || (gnt == GNT_WRITE);
      case (gnt)
        GNT_READ: begin
          ram_addr_q  <= rd_addr;
          ram_wdata_q <= '0;
        end
        GNT_CLEAR: begin
          ram_addr_q  <= clr_addr_q;
          ram_wdata_q <= clr_color_q;
        end
        GNT_WRITE: begin
          ram_addr_q  <= fifo_dout[AB+CB-1:CB];
          ram_wdata_q <= fifo_dout[CB-1:0];
        end
        default: begin
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
        end
      endcase
    end
  end

  assign ram.en    = ram_en_q;
  assign ram.we    = ram_we_q;
  assign ram.addr  = ram_addr_q;
  assign ram.wdata = ram_wdata_q;

  // Stage 0: command on the RAM port; last stage: ram.rdata valid, captured into rd_color.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_sr      <= '0;
      rd_color       <= '0;
      rd_color_valid <= 1'b0;
    end else begin
      rd_vld_sr      <= (READ_LATENCY-1)'({rd_vld_sr, (gnt == GNT_READ)});
      rd_color       <= rd_vld_sr[READ_LATENCY-2] ? ram.rdata : '0;
      rd_color_valid <= rd_vld_sr[READ_LATENCY-2];
    end
  end

`ifdef FB_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stall_count <= '0;
    end else if (wr_valid && !wr_ready && (wr_stall_count != 16'hFFFF)) begin
      wr_stall_count <= wr_stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;
  localparam int PW = 12;
  localparam int CB = 2;
  localparam int SS = 2;
  localparam int XB = 4;
  localparam int YB = 4;
  localparam int D  = 4;
  localparam int AB = XB + YB;
  localparam int NADDR = 1 << AB;

  logic clk, rst;
  logic rd_valid;
  logic [PW-1:0] rd_x, rd_y;
  logic [CB-1:0] rd_color;
  logic rd_color_valid;
  logic wr_valid, wr_ready;
  logic [AB-1:0] wr_addr;
  logic [CB-1:0] wr_data;
  logic clr_req;
  logic [CB-1:0] clr_color;
  logic clr_busy, clr_done;
`ifdef FB_PORT_ARBITER_STATS_EN
  logic [15:0] wr_stall_count;
`endif

  fb_ram_if #(.ADDR_W(AB), .DATA_W(CB)) ram_bus ();

  fb_port_arbiter #(
    .PIXEL_DIM_WIDTH(PW), .COLOR_BITS(CB), .SCALE_SHIFT(SS),
    .FB_X_BITS(XB), .FB_Y_BITS(YB), .WR_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
    .rd_color(rd_color), .rd_color_valid(rd_color_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram(ram_bus)
`ifdef FB_PORT_ARBITER_STATS_EN
    , .wr_stall_count(wr_stall_count)
`endif
  );

  // Single-port synchronous RAM.
  logic [CB-1:0] mem [NADDR];
  always @(posedge clk) begin
    if (ram_bus.en) begin
      if (ram_bus.we) mem[ram_bus.addr] <= ram_bus.wdata;
      else            ram_bus.rdata <= mem[ram_bus.addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: intended framebuffer contents, pending writes, clear progress.
  typedef struct { logic [AB-1:0] a; logic [CB-1:0] d; } wr_t;
  typedef struct { logic v; logic [CB-1:0] c; } rd_t;
  logic [CB-1:0] shadow [NADDR];
  wr_t wq[$];
  rd_t pipe[$];
  logic m_busy, m_done, last_rst;
  int   m_caddr;
  logic [CB-1:0] m_ccol;
  logic e_en, e_we;
  int   e_addr, e_wdata;
  int   m_stall;
  int   checks = 0;
  int   errors = 0;
  int   busy_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rd_t z;
    z.v = 1'b0; z.c = '0;
    wq.delete();
    pipe.delete();
    repeat (3) pipe.push_back(z);
    m_busy = 0; m_done = 0; m_caddr = 0; m_ccol = '0;
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    m_stall = 0; last_rst = 1;
  endtask

  // One clock cycle: check the state left by the previous edge, drive new
  // inputs, then advance the model through the coming edge.
  task automatic cyc(input logic rv, input int x, input int y, input logic wv,
                     input int wa, input int wd, input logic cr, input int cc,
                     input logic r);
    rd_t e;
    wr_t w;
    logic exp_ready, busy0, inr;
    int fx, fy, a;
    @(negedge clk);
    e = pipe.pop_front();
    chk("rd_color_valid", rd_color_valid, e.v);
    chk("rd_color", rd_color, e.c);
    chk("ram_en", ram_bus.en, e_en);
    if (e_en) begin
      chk("ram_we", ram_bus.we, e_we);
      chk("ram_addr", ram_bus.addr, e_addr);
      if (e_we) chk("ram_wdata", ram_bus.wdata, e_wdata);
    end
    if (last_rst) begin
      chk("rst_ram_we", ram_bus.we, 0);
      chk("rst_ram_addr", ram_bus.addr, 0);
      chk("rst_ram_wdata", ram_bus.wdata, 0);
    end
    chk("clr_busy", clr_busy, m_busy);
    chk("clr_done", clr_done, m_done);
    if (clr_busy === 1'b1) busy_seen++;
`ifdef FB_PORT_ARBITER_STATS_EN
    chk("wr_stall_count", wr_stall_count, m_stall);
`endif
    rst = r; rd_valid = rv; rd_x = PW'(x); rd_y = PW'(y);
    wr_valid = wv; wr_addr = AB'(wa); wr_data = CB'(wd);
    clr_req = cr; clr_color = CB'(cc);
    #1;
    exp_ready = !r && (wq.size() < D) && !m_busy;
    chk("wr_ready", wr_ready, exp_ready);
    if (r) begin
      model_reset();
    end else begin
      last_rst = 0;
      busy0 = m_busy;
      m_done = 0;
      if (wv && !exp_ready && m_stall < 65535) m_stall++;
      fx = x >> SS; fy = y >> SS;
      inr = rv && (fx < (1 << XB)) && (fy < (1 << YB));
      a = fy * (1 << XB) + fx;
      e.v = 0; e.c = '0;
      if (inr) begin
        e_en = 1; e_we = 0; e_addr = a;
        e.v = 1; e.c = shadow[a];
      end else if (busy0) begin
        e_en = 1; e_we = 1; e_addr = m_caddr; e_wdata = m_ccol;
        shadow[m_caddr] = m_ccol;
        if (m_caddr == NADDR - 1) begin m_busy = 0; m_done = 1; end
        else m_caddr++;
      end else if (wq.size() > 0) begin
        w = wq.pop_front();
        e_en = 1; e_we = 1; e_addr = w.a; e_wdata = w.d;
        shadow[w.a] = w.d;
      end else begin
        e_en = 0; e_we = 0;
      end
      pipe.push_back(e);
      if (wv && exp_ready) begin
        w.a = AB'(wa); w.d = CB'(wd);
        wq.push_back(w);
      end
      if (!busy0 && cr) begin m_busy = 1; m_caddr = 0; m_ccol = CB'(cc); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic scan();
    for (int a = 0; a < NADDR; a++)
      cyc(1, ((a % (1 << XB)) << SS) + $urandom_range(0, 3),
             ((a / (1 << XB)) << SS) + $urandom_range(0, 3), 0, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < NADDR; i++) begin mem[i] = '0; shadow[i] = '0; end
    rst = 1; rd_valid = 0; rd_x = '0; rd_y = '0; wr_valid = 0; wr_addr = '0;
    wr_data = '0; clr_req = 0; clr_color = '0;
    repeat (2) @(negedge clk);
    model_reset();
    idle(3);

    // Read latency: write 1 to {row 0, col 5}, read x=20 then x=24.
    cyc(0, 0, 0, 1, 5, 1, 0, 0, 0);
    idle(2);
    cyc(1, 20, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 24, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Read priority and FIFO boundary: reads held while writes pile up.
    for (int i = 0; i < 100; i++)
      cyc(1, $urandom_range(0, 63), $urandom_range(0, 63), i < 7,
          $urandom_range(0, NADDR-1), $urandom_range(0, 3), 0, 0, 0);
    idle(8);

    // Out-of-range read with a non-empty FIFO frees the slot for a write.
    cyc(1, 8, 8, 1, 17, 2, 0, 0, 0);
    cyc(1, 12, 8, 1, 18, 3, 0, 0, 0);
    cyc(1, 1 << (XB + SS), 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1 << (YB + SS), 0, 0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 79), $urandom_range(0, 79),
          $urandom_range(0, 9) < 4, $urandom_range(0, NADDR-1), $urandom_range(0, 3),
          $urandom_range(0, 299) == 0, $urandom_range(0, 3), 0);
    idle(300);
    scan();

    // Clear with no reads, simultaneous write, and an ignored re-request mid-clear.
    busy_seen = 0;
    cyc(0, 0, 0, 1, 33, 2, 1, 1, 0);
    idle(100);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 0);
    idle(200);
    chk("clr_busy_cycles", busy_seen, NADDR);
    scan();

    // Reset mid-clear with a write waiting behind it.
    cyc(0, 0, 0, 1, 40, 3, 1, 2, 0);
    idle(100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(20);
    scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the VGA pixel fetch path and the serial-link pixel writer.
- VGA reads have absolute priority and a fixed latency.
- Serial writes are buffered in a small FIFO and retired in cycles with no read (blanking, out-of-range pixels).
- A clear sequencer fills the whole framebuffer with one colour using those same free cycles.

Parameters:
- PIXEL_DIM_WIDTH, 12, width of the rd_x and rd_y screen coordinates.
- COLOR_BITS, 1, pixel colour width.
- SCALE_SHIFT, 2, screen-to-framebuffer downscale, as log2 of the pixel replication factor.
- FB_X_BITS, 9, framebuffer column address bits.
- FB_Y_BITS, 9, framebuffer row address bits.
- WR_FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- rd_valid  in  1  VGA requests the pixel at (rd_x, rd_y) this cycle.
- rd_x  in  PIXEL_DIM_WIDTH  screen x.
- rd_y  in  PIXEL_DIM_WIDTH  screen y.
- rd_color  out  COLOR_BITS  fetched colour, 3 cycles after the request.
- rd_color_valid  out  1  rd_color corresponds to an in-range request.
- wr_valid  in  1  serial writer offers a write.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  FB_X_BITS+FB_Y_BITS  write address, {row, col}.
- wr_data  in  COLOR_BITS  write colour.
- clr_req  in  1  pulse; start a framebuffer clear.
- clr_color  in  COLOR_BITS  fill colour, sampled on clr_req.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  FB_X_BITS+FB_Y_BITS  RAM address.
- ram_wdata  out  COLOR_BITS  RAM write data.
- ram_rdata  in  COLOR_BITS  RAM read data; valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset:
  - All outputs 0, except wr_ready, which is 1 from the first cycle after reset.
  - FIFO emptied, read pipeline valids cleared, state IDLE.
  - Reset mid-clear or mid-read aborts with no clr_done.
  - Pending FIFO writes are discarded.
- Address mapping:
  - fx = rd_x >> SCALE_SHIFT, fy = rd_y >> SCALE_SHIFT.
  - The request is in-range when fx < 2^FB_X_BITS and fy < 2^FB_Y_BITS.
  - RAM address = {fy[FB_Y_BITS-1:0], fx[FB_X_BITS-1:0]}.
- Per-cycle arbitration (combinational; RAM outputs registered), in priority order:
  - (1) rd_valid && in-range: read.
  - (2) state CLEAR: clear write.
  - (3) FIFO non-empty: FIFO write, popping the FIFO.
  - (4) none: ram_en=0.
- Read pipeline, with the request in cycle N:
  - RAM ports drive the read in cycle N+1.
  - ram_rdata is valid in cycle N+2.
  - rd_color and rd_color_valid are registered and visible in cycle N+3. Fixed latency 3 (localparam READ_LATENCY).
  - Out-of-range or rd_valid=0 requests give rd_color=0, rd_color_valid=0 at N+3, and free the slot for rule (2)/(3).
  - Back-to-back reads sustain 1 per cycle.
- Write FIFO:
  - wr_ready = !full && !clr_busy.
  - No push when full, even with a simultaneous pop.
  - Simultaneous push and pop when non-full are both applied; count unchanged.
  - Writes retire in FIFO order.
- Clear state machine (IDLE, CLEAR):
  - IDLE to CLEAR on clr_req. clr_addr=0, clr_color latched, clr_busy=1 from the next cycle.
  - In CLEAR, each granted slot writes clr_color to clr_addr and then increments clr_addr.
  - After the slot writing address all-ones: go to IDLE, clr_busy=0, clr_done=1 for one cycle.
  - clr_req while in CLEAR is ignored.
  - FIFO contents are preserved across a clear and retire after it, so they overwrite the cleared value.
- Simultaneous events:
  - clr_req together with a wr handshake in IDLE: the write is accepted into the FIFO and retires after the clear.
  - A read always pre-empts a clear or FIFO write; the preempted operation is retried the next free cycle and never lost.

Optional Feature:
- Macro FB_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds output wr_stall_count, 16 bits, saturating.
  - Increments each cycle wr_valid && !wr_ready.
  - Cleared by rst.
- Undefined:
  - Port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_BITS = FB_X_BITS+FB_Y_BITS.
  - READ_LATENCY = 3.
  - Clear-state enum typedef (ST_IDLE, ST_CLEAR).
  - Grant-source enum (GNT_NONE, GNT_READ, GNT_CLEAR, GNT_WRITE).
- One sub-module fb_wr_fifo:
  - Synchronous FIFO of {addr, data}, WR_FIFO_DEPTH entries.
  - Ports: push, pop, full, empty, dout.
  - Same clk/rst.

Test Plan:
- Read latency: write 1 to address {row 0, col 5} via FIFO during idle; then rd_valid with rd_x=20, rd_y=0. Expect rd_color=1, rd_color_valid=1 exactly 3 cycles later; rd_x=24 the next cycle returns 0.
- Read priority: hold rd_valid=1 in-range for 100 cycles while pushing 4 writes. Expect wr_ready=0 after the 4th, no ram_we during the reads, and all 4 writes retired in order within 4 cycles after rd_valid drops.
- FIFO boundary: with rd_valid=1, push until full. Expect wr_ready=0 at count=WR_FIFO_DEPTH and no data loss; then drop rd_valid and see exactly 4 RAM writes.
- Out of range: rd_x = 2^(FB_X_BITS+SCALE_SHIFT) with a non-empty FIFO. Expect rd_color_valid=0 and a FIFO write in that slot.
- Clear: clr_req with clr_color=1 and no reads. Expect clr_busy for 2^18 write cycles, clr_done one pulse, every address read back 1. A clr_req mid-clear adds no extra cycles.
- Reset mid-clear at clr_addr=1000. Expect clr_busy=0, FIFO empty, no clr_done, outputs 0 the cycle after rst.
